piso_tx: RTL
============

Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter built from D flip-flops.
- Accepts a parallel word through a valid/ready load handshake and shifts it out MSB-first on a single serial line.
- Each bit advances only on a clock edge where the shift enable `en` is high; with `en` low the current bit is held, as in a latch hold phase.
- Forms the transmit end of the team's serial shift-register link and feeds the matching serial-in/parallel-out receiver.

Parameters:
- WIDTH, 8, number of data bits per frame (legal range 2 to 32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- din  input  WIDTH  parallel word to transmit.
- load_valid  input  1  din is valid this cycle.
- load_ready  output  1  transmitter can accept a word (registered).
- en  input  1  shift enable; one bit consumed per clk edge with en=1.
- sout  output  1  serial data, MSB first.
- sout_n  output  1  always ~sout.
- sframe  output  1  high while a frame bit is on sout.
- done  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Reset (rst_n=0, asynchronous), all registers cleared immediately:
  - state=IDLE, shift register=0, bit counter=0.
  - load_ready=1, sframe=0, done=0, sout=0, sout_n=1.
- Release of reset is synchronous to the next clk edge.
- Bit counter width is $clog2(WIDTH+1). The shift register is exactly WIDTH bits; no arithmetic overflow is possible.
- States: IDLE, SHIFT, PAR (only when the optional feature is built in), DONE.
- IDLE:
  - load_ready=1, sframe=0, sout=0.
  - Load is accepted on a clk edge with load_valid=1: shreg<=din, cnt<=0, state->SHIFT.
  - en is ignored in IDLE.
- SHIFT:
  - load_ready=0, sframe=1, sout=shreg[WIDTH-1].
  - On a clk edge with en=1: shreg shifts left one position (zero fill) and cnt increments.
  - On a clk edge with en=1 and cnt==WIDTH-1: state->DONE (or PAR when built in).
  - en=0 holds shreg, cnt and sout unchanged for any number of cycles.
- DONE:
  - Lasts exactly one cycle: done=1, sframe=0, sout=0, load_ready=0.
  - Next state is always IDLE.
- Latency, load accepted at edge N with en held high:
  - Bit WIDTH-1 appears on sout after edge N.
  - Bit 0 appears after edge N+WIDTH-1.
  - done=1 after edge N+WIDTH.
  - load_ready=1 after edge N+WIDTH+1.
  - Minimum frame-to-frame spacing is WIDTH+2 cycles.
- Boundary conditions:
  - load_valid while load_ready=0 is ignored; din is not sampled. The sender must hold load_valid until load_ready is high.
  - en and load_valid high in the same IDLE cycle: the load is taken, and no bit is consumed on that edge.
  - en changing every cycle: each bit is held for the en=0 cycles plus one.
  - rst_n low mid-frame aborts the frame: sout goes to 0 and sframe to 0 immediately, and done is never pulsed for the aborted frame.
  - sout and sout_n are never equal, including during reset.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - At load, the even parity of din (XOR of all bits) is captured into a register.
  - After the last data bit, state PAR drives sout=parity bit with sframe=1.
  - The parity bit advances to DONE on the next clk edge with en=1.
  - Frame length is WIDTH+1 bits, so done arrives one en-cycle later.
- Undefined: PAR state and parity register are absent; frame is exactly WIDTH bits.

Test Plan:
- Reset then load 8'hA5 with en=1 constantly:
  - sout sequence is 1,0,1,0,0,1,0,1 on consecutive cycles, sout_n is the inverse, sframe high for 8 cycles.
  - done pulses for one cycle, load_ready returns 2 cycles after the last bit.
- Load 8'hC3 with en toggling every cycle (start en=0): each bit is held for exactly 2 cycles, sequence 1,1,0,0,0,0,1,1, 16 cycles of sframe.
- Load 8'h0F, then drive load_valid=1 with din=8'hFF during SHIFT: second word ignored, sout sequence stays 0,0,0,0,1,1,1,1, and 8'hFF is accepted only once load_ready=1.
- Load 8'hFF, pull rst_n low asynchronously mid-clock after 3 bits:
  - sout=0, sout_n=1, sframe=0, load_ready=1 immediately.
  - No done pulse.
  - The next load of 8'h81 transmits cleanly.
- load_valid held high with alternating din 8'h55/8'hAA: frames go out back-to-back with exactly WIDTH+2 cycle spacing, and no word is duplicated or dropped.
- With PISO_TX_PARITY_EN defined:
  - 8'hA5 yields 9 bits, the last being 0.
  - 8'h07 yields a final parity bit of 1.
  - done is delayed by one en-cycle versus the build without the macro.

Source files
------------

// File: rtl/piso_tx_if.sv
// piso_tx_if: load handshake and serial-line bundle for the piso_tx transmitter.
//
// Signals:
//   din        parallel word offered for transmission (WIDTH bits)
//   load_valid din is valid this cycle
//   load_ready transmitter can accept a word
//   en         shift enable, one bit consumed per clock edge with en=1
//   sout       serial data, MSB first
//   sout_n     complement of sout
//   sframe     high while a frame bit is on sout
//   done       one-cycle pulse after the last bit is consumed
//
// Modports:
//   master  word source / line consumer side
//   slave   the transmitter itself
interface piso_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             en;
    logic             sout;
    logic             sout_n;
    logic             sframe;
    logic             done;

    modport master (
        output din, load_valid, en,
        input  load_ready, sout, sout_n, sframe, done
    );

    modport slave (
        input  din, load_valid, en,
        output load_ready, sout, sout_n, sframe, done
    );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter.
//
// A word is loaded through a valid/ready handshake and shifted out MSB first.
// Each bit advances only on a clock edge with en=1; en=0 holds the current bit.
// A one-cycle done pulse follows the last bit, then the transmitter returns to
// idle and raises load_ready again.
//
// Optional feature (macro PISO_TX_PARITY_EN): an even-parity bit (XOR of the
// loaded word) is appended after the data bits, making the frame WIDTH+1 bits.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    piso_tx_if slave modport (din, load_valid, load_ready, en,
//          sout, sout_n, sframe, done)
//
// Parameters:
//   WIDTH  data bits per frame, 2..32
module piso_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    piso_tx_if.slave bus
);

    localparam int unsigned    CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
`ifdef PISO_TX_PARITY_EN
        StPar   = 2'd2,
`endif
        StDone  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             load_ready_q;
`ifdef PISO_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic sout;
    logic sframe;
    logic done;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            cnt_q        <= '0;
            load_ready_q <= 1'b1;
`ifdef PISO_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            // Registered ready: high exactly while the next state is idle.
            load_ready_q <= (state_d == StIdle);
`ifdef PISO_TX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                // en is deliberately ignored here: the load edge consumes no bit.
                if (bus.load_valid) begin
                    shreg_d = bus.din;
                    cnt_d   = '0;
`ifdef PISO_TX_PARITY_EN
                    par_d   = ^bus.din;
`endif
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bus.en) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
`ifdef PISO_TX_PARITY_EN
                        state_d = StPar;
`else
                        state_d = StDone;
`endif
                    end
                end
            end
`ifdef PISO_TX_PARITY_EN
            StPar: begin
                if (bus.en) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode, purely from registered state so reset forces sout low at once
    always_comb begin
        sout   = 1'b0;
        sframe = 1'b0;
        done   = 1'b0;
        unique case (state_q)
            StShift: begin
                sframe = 1'b1;
                sout   = shreg_q[WIDTH-1];
            end
`ifdef PISO_TX_PARITY_EN
            StPar: begin
                sframe = 1'b1;
                sout   = par_q;
            end
`endif
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.sout       = sout;
    assign bus.sout_n     = ~sout;
    assign bus.sframe     = sframe;
    assign bus.done       = done;
    assign bus.load_ready = load_ready_q;

endmodule
